// File: rtl/vs_sci_sequencer.sv
// SCI command sequencer: frames one 16-bit register read/write as a 4-byte
// SPI transfer with chip-select setup/hold, DREQ gating and a response pulse.
module vs_sci_sequencer #(
  parameter int unsigned CS_SETUP     = 4,
  parameter int unsigned CS_HOLD      = 4,
  parameter logic [15:0] DREQ_TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  input  logic        dreq,
  output logic        xcs,
  output logic        spi_wr_en,
  output logic [7:0]  spi_data_in,
  input  logic        spi_rx_done,
  input  logic [7:0]  spi_data_out
);

  localparam logic [15:0] SETUP_T = 16'(CS_SETUP);
  localparam logic [15:0] HOLD_T  = 16'(CS_HOLD);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_DREQ, ST_SETUP, ST_LAUNCH, ST_WAIT_BYTE, ST_HOLD, ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]  idx_q, idx_d;
  logic        write_q, write_d;
  logic [3:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        xcs_q, xcs_d;
  logic [7:0]  spi_data_q, spi_data_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] rdata_q, rdata_d;

  // Frame layout: opcode, zero-extended address, data high, data low.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic wr,
                                            input logic [3:0] addr, input logic [15:0] wdata);
    logic [7:0] b;
    case (idx)
      2'd0:    b = wr ? 8'h02 : 8'h03;
      2'd1:    b = {4'h0, addr};
      2'd2:    b = wdata[15:8];
      default: b = wdata[7:0];
    endcase
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    xcs_d      = xcs_q;
    spi_data_d = spi_data_q;
    rx_d       = rx_q;
    rdata_d    = rdata_q;
    cnt_inc    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        xcs_d = 1'b1;
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_write ? cmd_wdata : 16'h0000;
          idx_d   = 2'd0;
          cnt_d   = 16'd0;
          err_d   = 1'b0;
          state_d = ST_WAIT_DREQ;
        end
      end
      ST_WAIT_DREQ: begin
        if (dreq) begin
          xcs_d   = 1'b0;
          cnt_d   = 16'd0;
          state_d = ST_SETUP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DREQ_TIMEOUT) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_SETUP: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= SETUP_T) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: state_d = ST_WAIT_BYTE;
      ST_WAIT_BYTE: begin
        if (spi_rx_done) begin
          if (!write_q && idx_q == 2'd2) rx_d[15:8] = spi_data_out;
          if (!write_q && idx_q == 2'd3) rx_d[7:0]  = spi_data_out;
          if (idx_q == 2'd3) begin
            cnt_d   = 16'd0;
            state_d = ST_HOLD;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= HOLD_T) begin
          xcs_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The launch byte is registered so it stays put until the byte completes.
    if (state_d == ST_LAUNCH) spi_data_d = frame_byte(idx_d, write_q, addr_q, wdata_q);
    if (state_d == ST_DONE && !err_d && !write_q) rdata_d = rx_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      idx_q      <= 2'd0;
      write_q    <= 1'b0;
      addr_q     <= 4'h0;
      wdata_q    <= 16'h0000;
      err_q      <= 1'b0;
      xcs_q      <= 1'b1;
      spi_data_q <= 8'h00;
      rx_q       <= 16'h0000;
      rdata_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      xcs_q      <= xcs_d;
      spi_data_q <= spi_data_d;
      rx_q       <= rx_d;
      rdata_q    <= rdata_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = ~cmd_ready;
  assign rsp_valid   = (state_q == ST_DONE);
  assign rsp_err     = (state_q == ST_DONE) & err_q;
  assign rsp_rdata   = rdata_q;
  assign xcs         = xcs_q;
  assign spi_wr_en   = (state_q == ST_LAUNCH);
  assign spi_data_in = spi_data_q;

endmodule

// File: tb/tb_vs_sci_sequencer.sv
// Randomised self-checking bench for vs_sci_sequencer with a behavioural
// SPI slave and an arithmetic timing/data model of each command.
module tb_vs_sci_sequencer;

  localparam int S   = 3;
  localparam int H   = 5;
  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic        busy, dreq, xcs, spi_wr_en;
  logic [7:0]  spi_data_in;
  logic        spi_rx_done;
  logic [7:0]  spi_data_out;

  int          checks = 0;
  int          errors = 0;
  int          spi_b = 4;
  logic [7:0]  rx_hi = 8'h00, rx_lo = 8'h00;
  bit          inject = 1'b0;
  bit          wiggle = 1'b0;
  logic [15:0] exp_rdata = 16'h0000;
  int          rem = 0, byte_no = 0, cur_idx = 0;

  vs_sci_sequencer #(.CS_SETUP(S), .CS_HOLD(H), .DREQ_TIMEOUT(16'(TMO))) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
    .dreq(dreq), .xcs(xcs), .spi_wr_en(spi_wr_en), .spi_data_in(spi_data_in),
    .spi_rx_done(spi_rx_done), .spi_data_out(spi_data_out)
  );

  always #5 clk = ~clk;

  // SPI slave: answers each launch B cycles later; bytes 2/3 carry read data.
  always @(negedge clk) begin
    spi_rx_done = 1'b0;
    if (rst) begin
      rem     = 0;
      byte_no = 0;
    end else begin
      if (xcs) byte_no = 0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          spi_rx_done  = 1'b1;
          spi_data_out = (cur_idx == 2) ? rx_hi : (cur_idx == 3) ? rx_lo : 8'($urandom);
        end
      end else if (spi_wr_en) begin
        rem     = spi_b;
        cur_idx = byte_no;
        byte_no++;
      end else if (inject && $urandom_range(0, 3) == 0) begin
        spi_rx_done  = 1'b1;
        spi_data_out = 8'($urandom);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one command from an IDLE negedge; d = cycles dreq stays low after accept.
  task automatic applyStimulus(input bit wr, input logic [3:0] addr, input logic [15:0] wdata,
                               input int b, input int d, input bit keep,
                               input logic [7:0] hi, input logic [7:0] lo);
    logic [7:0] exp_bytes[4];
    logic [7:0] sent[$];
    int xcs_low = 0;
    int lat = -1;
    int j = 0;
    int w = 0;
    int bound;
    int exp_lat;
    bit exp_err;
    rx_hi = hi;
    rx_lo = lo;
    spi_b = b;
    exp_bytes[0] = wr ? 8'h02 : 8'h03;
    exp_bytes[1] = {4'h0, addr};
    exp_bytes[2] = wr ? wdata[15:8] : 8'h00;
    exp_bytes[3] = wr ? wdata[7:0] : 8'h00;
    exp_err = (d >= TMO);
    exp_lat = exp_err ? TMO : d + 1 + S + 4 * (b + 1) + H;
    bound   = exp_lat + 50;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    dreq      = (d == 0);
    while (!cmd_ready && w < 1000) begin
      w++;
      @(negedge clk);
    end
    checkOutput("ready_before_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
    checkOutput("accept_busy", 32'({cmd_ready, busy}), 32'b01);
    while (j <= bound && lat < 0) begin
      if (d > 0 && j == d) dreq = 1'b1;
      else if (wiggle && j > d) dreq = 1'($urandom);
      if (spi_wr_en) sent.push_back(spi_data_in);
      if (!xcs) xcs_low++;
      if (rsp_valid) lat = j;
      else begin
        j++;
        @(negedge clk);
      end
    end
    checkOutput("rsp_seen", 32'(lat >= 0), 32'd1);
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
    if (!exp_err && !wr) exp_rdata = {hi, lo};
    checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    checkOutput("byte_count", 32'(sent.size()), exp_err ? 32'd0 : 32'd4);
    foreach (sent[k]) if (k < 4) checkOutput($sformatf("byte%0d", k), 32'(sent[k]), 32'(exp_bytes[k]));
    checkOutput("xcs_low_cycles", 32'(xcs_low), exp_err ? 32'd0 : 32'(S + 4 * (b + 1) + H));
    @(negedge clk);
    checkOutput("after_rsp", 32'({rsp_valid, xcs, cmd_ready}), 32'b011);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int rv;
    int d;
    bit keep;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = 4'h0;
    cmd_wdata = 16'h0000;
    dreq = 1'b0;
    spi_rx_done = 1'b0;
    spi_data_out = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset_xcs_wren", 32'({xcs, spi_wr_en}), 32'b10);
    checkOutput("reset_spi_data", 32'(spi_data_in), 32'h00);
    checkOutput("reset_rsp", 32'({rsp_valid, rsp_err}), 32'b00);
    checkOutput("reset_rdata", 32'(rsp_rdata), 32'h0000);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", 32'({cmd_ready, busy}), 32'b10);

    $display("[TB] directed write/read");
    applyStimulus(1'b1, 4'h0, 16'h0800, 16, 0, 1'b0, 8'hAA, 8'h55);
    applyStimulus(1'b0, 4'hB, 16'hFFFF, 5, 0, 1'b0, 8'h12, 8'h34);

    $display("[TB] dreq timeout and late dreq");
    applyStimulus(1'b1, 4'h5, 16'hBEEF, 4, TMO + 10, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 4'h7, 16'h0000, 3, 100, 1'b0, 8'h9C, 8'h3E);

    $display("[TB] reset mid-transfer");
    cmd_write = 1'b1;
    cmd_addr  = 4'h3;
    cmd_wdata = 16'hA55A;
    dreq      = 1'b1;
    spi_b     = 6;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 300 && n < 3; k++) begin
      if (spi_wr_en) n++;
      if (n < 3) @(negedge clk);
    end
    checkOutput("rst_third_launch", 32'(n), 32'd3);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_outputs", 32'({xcs, spi_wr_en, rsp_valid}), 32'b100);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    exp_rdata = 16'h0000;
    rv = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) rv++;
    end
    checkOutput("rst_no_rsp", 32'(rv), 32'd0);
    checkOutput("rst_rdata_cleared", 32'(rsp_rdata), 32'h0000);
    applyStimulus(1'b0, 4'hC, 16'h0000, 2, 0, 1'b0, 8'h5A, 8'hC3);

    $display("[TB] back-to-back commands with spurious rx_done");
    inject = 1'b1;
    for (int i = 0; i < 6; i++)
      applyStimulus(1'($urandom), 4'($urandom), 16'($urandom), $urandom_range(1, 6), 0,
                    (i < 5), 8'($urandom), 8'($urandom));

    $display("[TB] randomised commands");
    wiggle = 1'b1;
    for (int i = 0; i < 20; i++) begin
      inject = 1'($urandom);
      d = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 5) : $urandom_range(0, 30);
      keep = (i < 19) ? 1'($urandom) : 1'b0;
      applyStimulus(1'($urandom), 4'($urandom), 16'($urandom), $urandom_range(1, 10), d,
                    keep, 8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
